memory_stage: RTL and testbench

- Pipeline stage directly downstream of execute.
- Consumes the registered EX/MEM outputs: ALU result, store data, set value, next PC, control bits.
- Issues one data-memory access per load/store over a ready/done handshake, stalling the pipeline while memory is busy.
- Selects the writeback value and registers it into the MEM/WB pipeline register for the writeback stage.

---
 rtl/memory_stage_pkg.sv | 16 +
 rtl/mem_wb_reg.sv | 57 +++++
 rtl/memory_stage.sv | 158 +++++++++++++++
 tb/tb_memory_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared encodings for the memory stage: writeback-source selects and FSM states.
package memory_stage_pkg;

    localparam logic [2:0] WB_ALU  = 3'd0;
    localparam logic [2:0] WB_MEM  = 3'd1;
    localparam logic [2:0] WB_SET  = 3'd2;
    localparam logic [2:0] WB_PC   = 3'd3;
    localparam logic [2:0] WB_REG2 = 3'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        HALTED = 2'd2
    } state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. load captures everything, bubble clears the
// side-effecting bits (regWrt, halt), kill clears only regWrt.
module mem_wb_reg #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              bubble_i,
    input  logic              kill_i,
    input  logic [DATA_W-1:0] wbData_i,
    input  logic              regWrt_i,
    input  logic [REG_AW-1:0] writeReg_i,
    input  logic [15:0]       instr_i,
    input  logic              halt_i,
    output logic [DATA_W-1:0] wbData_o,
    output logic              regWrt_o,
    output logic [REG_AW-1:0] writeReg_o,
    output logic [15:0]       instr_o,
    output logic              halt_o
);

    logic [DATA_W-1:0] wbData_q;
    logic              regWrt_q;
    logic [REG_AW-1:0] writeReg_q;
    logic [15:0]       instr_q;
    logic              halt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbData_q   <= '0;
            regWrt_q   <= 1'b0;
            writeReg_q <= '0;
            instr_q    <= '0;
            halt_q     <= 1'b0;
        end else if (load_i) begin
            wbData_q   <= wbData_i;
            regWrt_q   <= regWrt_i;
            writeReg_q <= writeReg_i;
            instr_q    <= instr_i;
            halt_q     <= halt_i;
        end else if (bubble_i) begin
            regWrt_q   <= 1'b0;
            halt_q     <= 1'b0;
        end else if (kill_i) begin
            regWrt_q   <= 1'b0;
        end
    end

    assign wbData_o   = wbData_q;
    assign regWrt_o   = regWrt_q;
    assign writeReg_o = writeReg_q;
    assign instr_o    = instr_q;
    assign halt_o     = halt_q;

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues one data-memory access per load/store, stalls
// upstream while the access is outstanding, and fills the MEM/WB register.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 3,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] aluOut,
    input  logic [DATA_W-1:0] reg2Data,
    input  logic [DATA_W-1:0] setVal,
    input  logic [DATA_W-1:0] nextPc,
    input  logic [15:0]       instr,
    input  logic              memEn,
    input  logic              memWrt,
    input  logic              regWrt,
    input  logic [2:0]        regWrtSrc,
    input  logic [REG_AW-1:0] writeReg,
    input  logic              halt,
    input  logic              errIn,
    input  logic [DATA_W-1:0] dmemRdData,
    input  logic              dmemDone,
    output logic [DATA_W-1:0] dmemAddr,
    output logic [DATA_W-1:0] dmemWrData,
    output logic              dmemEn,
    output logic              dmemWr,
    output logic              memStall,
    output logic [DATA_W-1:0] wbData,
    output logic              regWrtOut,
    output logic [REG_AW-1:0] writeRegOut,
    output logic [15:0]       instrOut,
    output logic              haltOut,
    output logic              errOut
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q;
    logic              err_set;
    logic              req, stall, load, bubble, kill;
    logic              fault;
    logic [DATA_W-1:0] wb_sel;

    always_comb begin
        wb_sel = '0;
        case (regWrtSrc)
            WB_ALU:  wb_sel = aluOut;
            WB_MEM:  wb_sel = dmemRdData;
            WB_SET:  wb_sel = setVal;
            WB_PC:   wb_sel = nextPc;
            WB_REG2: wb_sel = reg2Data;
            default: wb_sel = '0;
        endcase
    end

    // Anything that faults the instruction before a request goes out.
    assign fault = errIn | (regWrtSrc > WB_REG2) | (memEn & (aluOut[0] | halt));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req     = 1'b0;
        stall   = 1'b0;
        load    = 1'b0;
        bubble  = 1'b0;
        kill    = 1'b0;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (fault) begin
                    load    = 1'b1;
                    err_set = 1'b1;
                    state_d = HALTED;
                end else if (memEn) begin
                    req = 1'b1;
                    if (dmemDone) begin
                        load = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        bubble  = 1'b1;
                        cnt_d   = CW'(1);
                        state_d = BUSY;
                    end
                end else begin
                    load = 1'b1;
                    if (halt) state_d = HALTED;
                end
            end
            BUSY: begin
                req = 1'b1;
                if (dmemDone) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CW'(MAX_WAIT)) begin
                    stall   = 1'b1;
                    bubble  = 1'b1;
                    err_set = 1'b1;
                    cnt_d   = '0;
                    state_d = HALTED;
                end else begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            HALTED: kill = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_q | err_set;
        end
    end

    // Request and stall drop the moment reset rises, abandoning any access.
    assign dmemEn     = req & ~rst;
    assign dmemWr     = req & memWrt & ~rst;
    assign memStall   = stall & ~rst;
    assign dmemAddr   = aluOut;
    assign dmemWrData = reg2Data;
    assign errOut     = err_q;

    mem_wb_reg #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_mem_wb (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .bubble_i   (bubble),
        .kill_i     (kill),
        .wbData_i   (wb_sel),
        .regWrt_i   (regWrt & ~err_set),
        .writeReg_i (writeReg),
        .instr_i    (instr),
        .halt_i     (halt & ~err_set),
        .wbData_o   (wbData),
        .regWrt_o   (regWrtOut),
        .writeReg_o (writeRegOut),
        .instr_o    (instrOut),
        .halt_o     (haltOut)
    );

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: driver issues instructions and pushes the
// reference outcome, a negedge monitor pops and compares at each commit.
module tb_memory_stage;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] aluOut = '0, reg2Data = '0, setVal = '0, nextPc = '0, instr = '0;
    logic        memEn = 1'b0, memWrt = 1'b0, regWrt = 1'b0, halt = 1'b0, errIn = 1'b0;
    logic [2:0]  regWrtSrc = '0, writeReg = '0;
    logic [15:0] dmemRdData = '0;
    logic        dmemDone = 1'b0;
    logic [15:0] dmemAddr, dmemWrData, wbData, instrOut;
    logic        dmemEn, dmemWr, memStall, regWrtOut, haltOut, errOut;
    logic [2:0]  writeRegOut;

    memory_stage #(.DATA_W(16), .REG_AW(3), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .aluOut(aluOut), .reg2Data(reg2Data), .setVal(setVal),
        .nextPc(nextPc), .instr(instr), .memEn(memEn), .memWrt(memWrt), .regWrt(regWrt),
        .regWrtSrc(regWrtSrc), .writeReg(writeReg), .halt(halt), .errIn(errIn),
        .dmemRdData(dmemRdData), .dmemDone(dmemDone), .dmemAddr(dmemAddr),
        .dmemWrData(dmemWrData), .dmemEn(dmemEn), .dmemWr(dmemWr), .memStall(memStall),
        .wbData(wbData), .regWrtOut(regWrtOut), .writeRegOut(writeRegOut),
        .instrOut(instrOut), .haltOut(haltOut), .errOut(errOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] wb;
        logic        rw;
        logic [2:0]  wr;
        logic [15:0] ins;
        logic        hlt;
        logic        err;
        bit          chk_data;
        int          stalls;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   total = 0, bad = 0;
    bit   act = 0, pend_commit = 0, pend_bubble = 0;
    int   stall_cnt = 0;
    bit   m_halted = 0, m_err = 0, m_halt = 0;

    function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h @%0t", nm, a, e, $time);
        end
    endfunction

    function automatic logic [15:0] ref_wb(logic [2:0] src, logic [15:0] alu, rd, sv, pc, r2);
        case (src)
            3'd0: return alu;
            3'd1: return rd;
            3'd2: return sv;
            3'd3: return pc;
            3'd4: return r2;
            default: return 16'h0;
        endcase
    endfunction

    // Monitor: results of the previous edge first, then classify this cycle.
    always @(negedge clk) begin
        if (pend_commit) begin
            pend_commit = 0;
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_underflow got=commit want=none");
            end else begin
                cur = sb.pop_front();
                chk("stall_cycles", stall_cnt, cur.stalls);
                chk("regWrtOut", regWrtOut, cur.rw);
                chk("haltOut", haltOut, cur.hlt);
                chk("errOut", errOut, cur.err);
                if (cur.chk_data) begin
                    chk("wbData", wbData, cur.wb);
                    chk("writeRegOut", writeRegOut, cur.wr);
                    chk("instrOut", instrOut, cur.ins);
                end
            end
            stall_cnt = 0;
        end else if (pend_bubble) begin
            pend_bubble = 0;
            chk("bubble_regWrt", regWrtOut, 0);
            chk("bubble_halt", haltOut, 0);
        end
        if (act && !rst) begin
            if (memStall) begin
                pend_bubble = 1;
                stall_cnt++;
            end else begin
                pend_commit = 1;
            end
        end
    end

    task automatic clear_inputs();
        memEn = 0; memWrt = 0; regWrt = 0; halt = 0; errIn = 0; dmemDone = 0;
        regWrtSrc = 0; writeReg = 0; aluOut = 0; reg2Data = 0; setVal = 0;
        nextPc = 0; instr = 0; dmemRdData = 0;
    endtask

    task automatic clear_model();
        sb.delete();
        pend_commit = 0; pend_bubble = 0; stall_cnt = 0; act = 0;
        m_halted = 0; m_err = 0; m_halt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1; clear_inputs(); clear_model();
        @(negedge clk); #1;
        rst = 0; #1;
        chk("rst_wbData", wbData, 0);
        chk("rst_regWrtOut", regWrtOut, 0);
        chk("rst_writeRegOut", writeRegOut, 0);
        chk("rst_instrOut", instrOut, 0);
        chk("rst_haltOut", haltOut, 0);
        chk("rst_errOut", errOut, 0);
        chk("rst_dmemEn", dmemEn, 0);
        chk("rst_memStall", memStall, 0);
        @(posedge clk); #1;
    endtask

    // L = cycles from request to dmemDone (0 = same cycle).
    task automatic issue(input logic me, mw, rw, input logic [2:0] src, wr,
                         input logic h, ei, input logic [15:0] alu, r2, sv, pc, ins, rd,
                         input int L);
        exp_t e;
        logic req;
        int   k;
        memEn = me; memWrt = mw; regWrt = rw; regWrtSrc = src; writeReg = wr;
        halt = h; errIn = ei; aluOut = alu; reg2Data = r2; setVal = sv;
        nextPc = pc; instr = ins; dmemRdData = rd;
        e.wb = ref_wb(src, alu, rd, sv, pc, r2);
        e.wr = wr; e.ins = ins; e.rw = 0; e.hlt = 0; e.err = m_err;
        e.chk_data = 1; e.stalls = 0; req = 0;
        if (m_halted) begin
            e.chk_data = 0; e.hlt = m_halt;
        end else if (ei || src > 3'd4 || (me && (alu[0] || h))) begin
            m_err = 1; m_halted = 1; e.err = 1;
        end else if (me) begin
            req = 1;
            if (L <= MAX_WAIT) begin
                e.stalls = L; e.rw = rw;
            end else begin
                e.stalls = MAX_WAIT + 1; e.chk_data = 0;
                m_err = 1; m_halted = 1; e.err = 1;
            end
        end else begin
            e.rw = rw; e.hlt = h;
            if (h) begin m_halted = 1; m_halt = 1; end
        end
        sb.push_back(e);
        act = 1; k = 0; dmemDone = (L == 0);
        @(negedge clk);
        chk("req_dmemEn", dmemEn, req);
        if (req) begin
            chk("req_dmemWr", dmemWr, mw);
            chk("req_dmemAddr", dmemAddr, alu);
        end
        while (memStall) begin
            @(posedge clk); #1;
            k++; dmemDone = (k == L);
            if (k > 40) begin
                total++; bad++;
                $display("FAIL stall_bound got=%0d want<=40", k);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        act = 0; dmemDone = 0;
    endtask

    task automatic rand_instr();
        logic me, mw, rw, h, ei;
        logic [2:0] src;
        logic [15:0] alu;
        int L, pick;
        me = 1'($urandom_range(0, 1)); mw = 1'($urandom_range(0, 1));
        rw = 1'($urandom_range(0, 1));
        src = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        alu = 16'($urandom) & 16'hFFFE;
        if ($urandom_range(0, 11) == 0) alu[0] = 1'b1;
        h  = ($urandom_range(0, 19) == 0);
        ei = ($urandom_range(0, 24) == 0);
        pick = $urandom_range(0, 9);
        if (pick < 7)       L = $urandom_range(0, 3);
        else if (pick == 7) L = MAX_WAIT;
        else if (pick == 8) L = MAX_WAIT + 1;
        else                L = $urandom_range(4, 8);
        issue(me, mw, rw, src, 3'($urandom), h, ei, alu, 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), 16'($urandom), L);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // zero-stall load hit
        issue(1, 0, 1, 3'd1, 3'd5, 0, 0, 16'h0010, 16'h0, 16'h0, 16'h0, 16'hA001, 16'hBEEF, 0);
        // store, done after 3 stall cycles
        issue(1, 1, 0, 3'd0, 3'd2, 0, 0, 16'h0020, 16'h1234, 16'h0, 16'h0, 16'hA002, 16'h0, 3);
        // non-memory ops through each writeback source
        issue(0, 0, 1, 3'd2, 3'd1, 0, 0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'hA003, 16'h5555, 0);
        issue(0, 0, 1, 3'd3, 3'd6, 0, 0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'hA004, 16'h5555, 0);
        issue(0, 0, 1, 3'd4, 3'd7, 0, 0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'hA005, 16'h5555, 0);
        // done exactly as the counter hits its limit
        issue(1, 0, 1, 3'd1, 3'd3, 0, 0, 16'h0030, 16'h0, 16'h0, 16'h0, 16'hA006, 16'hC0DE, MAX_WAIT);
        // unaligned load, then a follow-up that must not issue
        issue(1, 0, 1, 3'd1, 3'd4, 0, 0, 16'h0021, 16'h0, 16'h0, 16'h0, 16'hA007, 16'h0, 0);
        issue(1, 0, 1, 3'd0, 3'd4, 0, 0, 16'h0040, 16'h0, 16'h0, 16'h0, 16'hA008, 16'h0, 0);

        do_reset();
        // memory never answers
        issue(1, 0, 1, 3'd1, 3'd2, 0, 0, 16'h0050, 16'h0, 16'h0, 16'h0, 16'hB001, 16'h0, 999);
        issue(0, 0, 1, 3'd0, 3'd2, 0, 0, 16'h0052, 16'h0, 16'h0, 16'h0, 16'hB002, 16'h0, 0);

        do_reset();
        // halt, then a load behind it
        issue(0, 0, 0, 3'd0, 3'd0, 1, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hC001, 16'h0, 0);
        issue(1, 0, 1, 3'd1, 3'd3, 0, 0, 16'h0060, 16'h0, 16'h0, 16'h0, 16'hC002, 16'h0, 0);

        do_reset();
        // reset in the middle of an outstanding access
        act = 0;
        memEn = 1; regWrt = 1; regWrtSrc = 3'd1; aluOut = 16'h0070; dmemDone = 0;
        repeat (3) @(negedge clk);
        chk("busy_dmemEn", dmemEn, 1);
        chk("busy_memStall", memStall, 1);
        #2 rst = 1; #1;
        chk("async_dmemEn", dmemEn, 0);
        chk("async_memStall", memStall, 0);
        @(negedge clk); #1;
        rst = 0; clear_inputs(); clear_model();
        @(posedge clk); #1;
        issue(1, 0, 1, 3'd1, 3'd6, 0, 0, 16'h0072, 16'h0, 16'h0, 16'h0, 16'hD001, 16'h7777, 2);

        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int i = 0; i < 12; i++) rand_instr();
        end

        @(negedge clk); #1;
        @(negedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
